// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the EX-stage ALU control decoder and the HI/LO
// multiply/divide unit: R-type funct codes, main-control op classes, the
// 4-bit ALU control codes and the sequencer state encoding.
// Optional feature macro: MDU_DIV_EN (see mdu_alu_ctrl).
// ----------------------------------------------------------------------------
package mdu_pkg;

    // Main-control op classes carried on alu_op
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_NONE  = 2'b11;

    // R-type function codes
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // ALU control codes driven to the ALU
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// ----------------------------------------------------------------------------
// mdu_core
// Iterative unsigned datapath: shift-add multiplier and (with MDU_DIV_EN)
// restoring divider, one bit per step. Operands arrive already made
// non-negative; sign handling lives in the parent.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_start      load operands, clear counter (one cycle)
//   i_step       advance one iteration
//   i_op_div     operation is a divide (only with MDU_DIV_EN)
//   i_a          multiplier / dividend
//   i_b          multiplicand / divisor
//   o_hi, o_lo   product {hi,lo}, or remainder (hi) and quotient (lo)
//   o_last       current step is the final one (counter == DATA_W-1)
// Derived: CNT_W = $clog2(DATA_W)+1 counter width.
// ----------------------------------------------------------------------------
module mdu_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_step,
`ifdef MDU_DIV_EN
    input  logic              i_op_div,
`endif
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_last
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] r_hi;     // partial product high half / partial remainder
    logic [DATA_W-1:0] r_lo;     // multiplier shift reg / dividend-quotient shift reg
    logic [DATA_W-1:0] r_b;      // multiplicand / divisor
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_hi_nxt;
    logic [DATA_W-1:0] w_lo_nxt;
    logic [DATA_W:0]   w_sum;

`ifdef MDU_DIV_EN
    logic              r_div;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;
`endif

    // Multiply step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, hi, lo} right by one.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

`ifdef MDU_DIV_EN
    // Divide step: shift the next dividend bit into the remainder and try
    // subtracting the divisor; the extra top bit of w_diff is the borrow.
    // With a zero divisor the trial never borrows, so the quotient fills
    // with ones and the remainder ends up equal to the dividend.
    assign w_shift = {r_hi, r_lo[DATA_W-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_b};
`endif

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_hi_nxt = w_sum[DATA_W:1];
        w_lo_nxt = {w_sum[0], r_lo[DATA_W-1:1]};
`ifdef MDU_DIV_EN
        if (r_div) begin
            if (!w_diff[DATA_W+1]) begin
                w_hi_nxt = w_diff[DATA_W-1:0];
                w_lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[DATA_W-1:0];
                w_lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
            end
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_cnt <= '0;
        end else if (i_step) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef MDU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= 1'b0;
        end else if (i_start) begin
            r_div <= i_op_div;
        end
    end
`endif

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/mdu_alu_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_alu_ctrl
// EX-stage ALU control decoder with HI/LO registers and an iterative
// multiply/divide sequencer. Stalls the pipeline only when a HI/LO or
// mult/div instruction meets an operation already in flight.
//
// Macro MDU_DIV_EN: when defined, div/divu are supported; when undefined the
// divider is not built and div/divu decode as illegal.
//
// Parameters
//   DATA_W        operand and HI/LO width (even, >= 8)
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   valid_in      EX-stage instruction valid
//   flush         kill EX instruction, abort in-flight operation
//   alu_op        main-control op class
//   funct         R-type function field
//   rs_data       operand A / dividend / mthi-mtlo source
//   rt_data       operand B / divisor
//   alu_ctrl_out  4-bit ALU control code (combinational)
//   hilo_out      HI for mfhi, else LO (combinational)
//   stall         hold IF/ID/EX this cycle (combinational)
//   busy          operation in flight (decoded from the state register)
//   illegal_op    valid R-type with unsupported funct (combinational)
// ----------------------------------------------------------------------------
module mdu_alu_ctrl
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [3:0]        alu_ctrl_out,
    output logic [DATA_W-1:0] hilo_out,
    output logic              stall,
    output logic              busy,
    output logic              illegal_op
);

    mdu_state_e r_state;
    mdu_state_e w_state_nxt;

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_neg_q;     // negate product / quotient in FIX

    logic [3:0]        w_alu_ctrl;
    logic              w_illegal_funct;
    logic              w_rtype;
    logic              w_mul_op;
    logic              w_div_op;
    logic              w_hilo_funct;
    logic              w_free;
    logic              w_accept;
    logic              w_mthi;
    logic              w_mtlo;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg_q;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic              w_core_start;
    logic              w_core_step;
    logic              w_core_last;
    logic [DATA_W-1:0] w_core_hi;
    logic [DATA_W-1:0] w_core_lo;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0] w_fix_hi;
    logic [DATA_W-1:0] w_fix_lo;
    logic              w_fix_write;

`ifdef MDU_DIV_EN
    logic              r_neg_r;     // negate remainder in FIX
    logic              r_is_div;
`endif

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_ctrl      = ALU_NOP;
        w_illegal_funct = 1'b0;
        unique case (alu_op)
            AOP_ADD:  w_alu_ctrl = ALU_ADD;
            AOP_SUB:  w_alu_ctrl = ALU_SUB;
            AOP_NONE: w_alu_ctrl = ALU_NOP;
            AOP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: w_alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: w_alu_ctrl = ALU_SUB;
                    F_AND:         w_alu_ctrl = ALU_AND;
                    F_OR:          w_alu_ctrl = ALU_OR;
                    F_XOR:         w_alu_ctrl = ALU_XOR;
                    F_NOR:         w_alu_ctrl = ALU_NOR;
                    F_SLT:         w_alu_ctrl = ALU_SLT;
                    F_SLTU:        w_alu_ctrl = ALU_SLTU;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU:
                                   w_alu_ctrl = ALU_NOP;
`ifdef MDU_DIV_EN
                    F_DIV, F_DIVU: w_alu_ctrl = ALU_NOP;
`else
                    // Divider not built: div/divu are unsupported functs.
                    F_DIV, F_DIVU: w_illegal_funct = 1'b1;
`endif
                    default:       w_illegal_funct = 1'b1;
                endcase
            end
        endcase
    end

    assign alu_ctrl_out = w_alu_ctrl;
    assign illegal_op   = valid_in & (alu_op == AOP_RTYPE) & w_illegal_funct;

    // ------------------------------------------------------------------
    // HI/LO instruction classification. Only R-type instructions carry a
    // real funct field, so the class is qualified with alu_op.
    // ------------------------------------------------------------------
    assign w_rtype  = valid_in & (alu_op == AOP_RTYPE);
    assign w_mul_op = (funct == F_MULT) | (funct == F_MULTU);
`ifdef MDU_DIV_EN
    assign w_div_op = (funct == F_DIV) | (funct == F_DIVU);
`else
    assign w_div_op = 1'b0;
`endif
    assign w_hilo_funct = (funct == F_MFHI) | (funct == F_MFLO) |
                          (funct == F_MTHI) | (funct == F_MTLO) |
                          w_mul_op | w_div_op;

    assign busy  = (r_state != ST_IDLE);
    assign stall = w_rtype & busy & w_hilo_funct;

    assign w_free   = w_rtype & ~flush & ~busy;
    assign w_accept = w_free & (w_mul_op | w_div_op);
    assign w_mthi   = w_free & (funct == F_MTHI);
    assign w_mtlo   = w_free & (funct == F_MTLO);

    // Signed variants feed magnitudes to the core and remember the sign.
    // A zero divisor keeps the all-ones quotient uncorrected. The most
    // negative dividend over -1 needs no special case: its magnitude
    // negated back is the dividend itself, with remainder 0.
    assign w_signed = (funct == F_MULT) | (funct == F_DIV);
    assign w_a_neg  = w_signed & rs_data[DATA_W-1];
    assign w_b_neg  = w_signed & rt_data[DATA_W-1];
    assign w_abs_a  = w_a_neg ? -rs_data : rs_data;
    assign w_abs_b  = w_b_neg ? -rt_data : rt_data;
    assign w_neg_q  = (w_a_neg ^ w_b_neg) & ~(w_div_op & (rt_data == '0));

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_neg_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_neg_q <= w_neg_q;
            end
        end
    end

`ifdef MDU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
        end else if (w_accept) begin
            r_neg_r  <= w_a_neg & w_div_op;   // remainder takes the dividend's sign
            r_is_div <= w_div_op;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_core_start = 1'b0;
        w_core_step  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_core_start = 1'b1;
                    w_state_nxt  = w_div_op ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                w_core_step = 1'b1;
                if (w_core_last) w_state_nxt = ST_FIX;
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                w_core_step = 1'b1;
                if (w_core_last) w_state_nxt = ST_FIX;
            end
`endif
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // Abort wins over everything once an operation is in flight.
        if (flush && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    mdu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_core_start),
        .i_step   (w_core_step),
`ifdef MDU_DIV_EN
        .i_op_div (w_div_op),
`endif
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo),
        .o_last   (w_core_last)
    );

    // ------------------------------------------------------------------
    // Sign correction and HI/LO write-back
    // ------------------------------------------------------------------
    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_fix_hi = w_prod_fix[2*DATA_W-1:DATA_W];
        w_fix_lo = w_prod_fix[DATA_W-1:0];
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            w_fix_lo = r_neg_q ? -w_core_lo : w_core_lo;
            w_fix_hi = r_neg_r ? -w_core_hi : w_core_hi;
        end
`endif
    end

    assign w_fix_write = (r_state == ST_FIX) & ~flush;

    // NOTE: HI/LO are architectural state and are explicitly reset to zero;
    // a reset mid-operation therefore also discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix_write) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else begin
            if (w_mthi) r_hi <= rs_data;
            if (w_mtlo) r_lo <= rs_data;
        end
    end

    assign hilo_out = (funct == F_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_alu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mdu_alu_ctrl
// Self-checking bench for mdu_alu_ctrl. Directed stimulus; HI/LO reads are
// checked through a scoreboard queue drained by a monitor that fires when
// the DUT completes an mfhi/mflo (valid, not stalled), comparing the value
// and the number of stall cycles seen. Decode, busy and reset behaviour are
// checked directly. Divide tests follow MDU_DIV_EN.
// ----------------------------------------------------------------------------
module tb_mdu_alu_ctrl;
    import mdu_pkg::*;

    localparam int DATA_W = 32;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              valid_in = 1'b0;
    logic              flush    = 1'b0;
    logic [1:0]        alu_op   = 2'b00;
    logic [5:0]        funct    = 6'b000000;
    logic [DATA_W-1:0] rs_data  = '0;
    logic [DATA_W-1:0] rt_data  = '0;
    logic [3:0]        alu_ctrl_out;
    logic [DATA_W-1:0] hilo_out;
    logic              stall;
    logic              busy;
    logic              illegal_op;

    typedef struct {
        string       name;
        logic [31:0] value;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   stall_cnt = 0;

    always #5 clk = ~clk;

    mdu_alu_ctrl #(
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .flush        (flush),
        .alu_op       (alu_op),
        .funct        (funct),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .alu_ctrl_out (alu_ctrl_out),
        .hilo_out     (hilo_out),
        .stall        (stall),
        .busy         (busy),
        .illegal_op   (illegal_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'b000000;
        rs_data  = '0;
        rt_data  = '0;
    endtask

    task automatic decode_chk(input string name, input logic [1:0] op, input logic [5:0] f,
                              input logic v, input logic [3:0] exp_alu, input logic exp_ill);
        alu_op   = op;
        funct    = f;
        valid_in = v;
        #1;
        check({name, "_alu"}, 32'(alu_ctrl_out), 32'(exp_alu));
        check({name, "_ill"}, 32'(illegal_op), 32'(exp_ill));
    endtask

    // Present one R-type instruction for a single cycle.
    task automatic issue_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1;
        alu_op   = AOP_RTYPE;
        funct    = f;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Issue mfhi/mflo and hold it until the DUT stops stalling; the monitor
    // checks the value and stall count against the pushed expectation.
    task automatic read_hilo(input string name, input logic [5:0] f,
                             input logic [31:0] exp_val, input int exp_stalls);
        bit done;
        done = 1'b0;
        sb_q.push_back('{name, exp_val, exp_stalls});
        valid_in = 1'b1;
        alu_op   = AOP_RTYPE;
        funct    = f;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: stall still high after 100 cycles", name);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Monitor: a read completes on a cycle where mfhi/mflo is valid and not stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_in && (alu_op == AOP_RTYPE) &&
                ((funct == F_MFHI) || (funct == F_MFLO))) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_read: got %h expected no read", hilo_out);
                    end else begin
                        e = sb_q.pop_front();
                        check(e.name, hilo_out, e.value);
                        check({e.name, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_hilo", hilo_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- decode sweep ----------------
        decode_chk("dec_op00",   AOP_ADD,   6'b000000, 1'b0, ALU_ADD,  1'b0);
        decode_chk("dec_op01",   AOP_SUB,   6'b000000, 1'b0, ALU_SUB,  1'b0);
        decode_chk("dec_op11",   AOP_NONE,  6'b111111, 1'b1, ALU_NOP,  1'b0);
        decode_chk("dec_nor",    AOP_RTYPE, 6'b100111, 1'b0, ALU_NOR,  1'b0);
        decode_chk("dec_addu",   AOP_RTYPE, 6'b100001, 1'b0, ALU_ADD,  1'b0);
        decode_chk("dec_subu",   AOP_RTYPE, 6'b100011, 1'b0, ALU_SUB,  1'b0);
        decode_chk("dec_xor",    AOP_RTYPE, 6'b100110, 1'b0, ALU_XOR,  1'b0);
        decode_chk("dec_sltu",   AOP_RTYPE, 6'b101011, 1'b0, ALU_SLTU, 1'b0);
        decode_chk("dec_mfhi",   AOP_RTYPE, 6'b010000, 1'b0, ALU_NOP,  1'b0);
        decode_chk("dec_ill",    AOP_RTYPE, 6'b111111, 1'b1, ALU_NOP,  1'b1);
        decode_chk("dec_ill_nv", AOP_RTYPE, 6'b111111, 1'b0, ALU_NOP,  1'b0);
        idle_inputs();
        @(posedge clk);
        #1;

        // ---------------- reset value, mthi/mtlo ----------------
        read_hilo("rd_lo_reset", F_MFLO, 32'h0, 0);
        issue_op(F_MTHI, 32'h0000_1234, 32'h0);
        read_hilo("rd_hi_mthi", F_MFHI, 32'h0000_1234, 0);
        issue_op(F_MTLO, 32'h0000_5678, 32'h0);
        read_hilo("rd_lo_mtlo", F_MFLO, 32'h0000_5678, 0);

        // flush suppresses an mthi in the same cycle
        valid_in = 1'b1; alu_op = AOP_RTYPE; funct = F_MTHI; rs_data = 32'h0000_DEAD; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle_inputs();
        read_hilo("rd_hi_flush_mthi", F_MFHI, 32'h0000_1234, 0);

        // ---------------- flush during MUL iteration 10 ----------------
        issue_op(F_MULT, 32'd5, 32'd6);
        check("flush_busy_pre", 32'(busy), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_post", 32'(busy), 32'd0);
        read_hilo("rd_hi_flush", F_MFHI, 32'h0000_1234, 0);
        read_hilo("rd_lo_flush", F_MFLO, 32'h0000_5678, 0);

        // ---------------- multiply ----------------
        issue_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        read_hilo("mult_lo", F_MFLO, 32'hFFFF_FFEB, 33);
        read_hilo("mult_hi", F_MFHI, 32'hFFFF_FFFF, 0);

        // add issued while busy proceeds without stalling
        issue_op(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        valid_in = 1'b1; alu_op = AOP_RTYPE; funct = F_ADD;
        #1;
        check("add_busy", 32'(busy), 32'd1);
        check("add_stall", 32'(stall), 32'd0);
        check("add_alu", 32'(alu_ctrl_out), 32'(ALU_ADD));
        @(posedge clk);
        #1;
        idle_inputs();
        read_hilo("multu_lo", F_MFLO, 32'hFFFF_FFFE, 32);
        read_hilo("multu_hi", F_MFHI, 32'h0000_0001, 0);

        issue_op(F_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB);
        read_hilo("mult_nn_lo", F_MFLO, 32'd20, 33);
        read_hilo("mult_nn_hi", F_MFHI, 32'd0, 0);

`ifdef MDU_DIV_EN
        // ---------------- divide ----------------
        valid_in = 1'b1; alu_op = AOP_RTYPE; funct = F_DIVU;
        #1;
        check("divu_legal", 32'(illegal_op), 32'd0);
        idle_inputs();
        issue_op(F_DIVU, 32'd100, 32'd7);
        read_hilo("divu_lo", F_MFLO, 32'd14, 33);
        read_hilo("divu_hi", F_MFHI, 32'd2, 0);
        issue_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        read_hilo("div_neg_lo", F_MFLO, 32'hFFFF_FFFD, 33);
        read_hilo("div_neg_hi", F_MFHI, 32'hFFFF_FFFF, 0);
        issue_op(F_DIV, 32'd5, 32'd0);
        read_hilo("div_zero_lo", F_MFLO, 32'hFFFF_FFFF, 33);
        read_hilo("div_zero_hi", F_MFHI, 32'd5, 0);
        issue_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo("div_ovf_lo", F_MFLO, 32'h8000_0000, 33);
        read_hilo("div_ovf_hi", F_MFHI, 32'd0, 0);
        // operation to interrupt with reset
        issue_op(F_DIVU, 32'd100, 32'd7);
`else
        // ---------------- divider not built ----------------
        valid_in = 1'b1; alu_op = AOP_RTYPE; funct = F_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        #1;
        check("nodiv_ill", 32'(illegal_op), 32'd1);
        check("nodiv_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("nodiv_busy", 32'(busy), 32'd0);
        read_hilo("nodiv_lo", F_MFLO, 32'd20, 0);
        read_hilo("nodiv_hi", F_MFHI, 32'd0, 0);
        // operation to interrupt with reset
        issue_op(F_MULT, 32'd5, 32'd6);
`endif

        // ---------------- reset mid-operation ----------------
        repeat (5) @(posedge clk);
        #1;
        check("midrst_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        alu_op = AOP_RTYPE; funct = F_MFHI;
        #1;
        check("midrst_hi", hilo_out, 32'h0);
        valid_in = 1'b1; funct = F_MFLO;
        #1;
        check("midrst_lo", hilo_out, 32'h0);
        check("midrst_stall", 32'(stall), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_hilo("post_rst_lo", F_MFLO, 32'h0, 0);
        read_hilo("post_rst_hi", F_MFHI, 32'h0, 0);

        @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
